// File: rtl/dtree_pkg.sv
// -----------------------------------------------------------------------------
// dtree_pkg
// Shared definitions for the decision-tree walker: node word geometry, field
// offsets and widths, feature geometry and the walker state encoding.
// No ports; imported by dtree_node_cmp and dtree_walker.
// -----------------------------------------------------------------------------
package dtree_pkg;

   localparam int NODE_W       = 27;
   localparam int NUM_FEATURES = 5;
   localparam int FEAT_W       = 8;

   localparam int INT_BIT   = 0;
   localparam int SEL_LSB   = 1;
   localparam int SEL_W     = 3;
   localparam int PREC_LSB  = 4;
   localparam int PREC_W    = 3;
   localparam int THR_LSB   = 7;
   localparam int THR_W     = 8;
   localparam int LEFT_LSB  = 15;
   localparam int RIGHT_LSB = 21;
   localparam int CHILD_W   = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/dtree_node_cmp.sv
// -----------------------------------------------------------------------------
// dtree_node_cmp
// Reduced-precision unsigned compare used at every internal node. Only the
// upper precision+1 bits of the feature and threshold take part.
// Ports:
//    feature_i    selected feature value
//    threshold_i  node threshold
//    precision_i  p, number of extra bits below the MSB that are compared
//    go_left_o    1 when the truncated feature is <= the truncated threshold
// -----------------------------------------------------------------------------
module dtree_node_cmp
   import dtree_pkg::*;
(
   input  logic [FEAT_W-1:0] feature_i,
   input  logic [THR_W-1:0]  threshold_i,
   input  logic [PREC_W-1:0] precision_i,
   output logic              go_left_o
);

   logic [PREC_W-1:0] dropBits;

   // Keeping p+1 upper bits means discarding 7-p low bits; for a 3-bit p
   // that count is simply the bitwise inverse of p.
   assign dropBits = ~precision_i;

   // Shifting both operands right by the same amount compares only the kept bits.
   assign go_left_o = (feature_i >> dropBits) <= (threshold_i >> dropBits);

endmodule

// File: rtl/dtree_walker.sv
// -----------------------------------------------------------------------------
// dtree_walker
// Walks a register-based decision tree one node per cycle for one latched
// feature sample at a time, and returns the class of the reached leaf or an
// abort flag when the walk runs too long or hits a bad feature select.
// Ports:
//    clk_i, rst_i                  clock, synchronous active-high reset
//    in_valid_i / in_ready_o       sample handshake
//    x0_i .. x4_i                  feature values, latched on accept
//    cfg_we_i, cfg_addr_i,
//    cfg_data_i                    node-table write port (IDLE only)
//    out_valid_o / out_ready_i     result handshake
//    out_class_o, out_err_o        result class and abort flag
// -----------------------------------------------------------------------------
module dtree_walker
   import dtree_pkg::*;
#(
   parameter int NODES     = 64,
   parameter int MAX_STEPS = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [FEAT_W-1:0]  x0_i,
   input  logic [FEAT_W-1:0]  x1_i,
   input  logic [FEAT_W-1:0]  x2_i,
   input  logic [FEAT_W-1:0]  x3_i,
   input  logic [FEAT_W-1:0]  x4_i,
   input  logic               cfg_we_i,
   input  logic [CHILD_W-1:0] cfg_addr_i,
   input  logic [NODE_W-1:0]  cfg_data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [THR_W-1:0]   out_class_o,
   output logic               out_err_o
);

   localparam int AW = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int SW = $clog2(MAX_STEPS + 1);

   state_e            state_q, state_d;
   logic [AW-1:0]     cur_q, cur_d;
   logic [SW-1:0]     steps_q, steps_d;
   logic [THR_W-1:0]  class_q, class_d;
   logic              err_q, err_d;
   logic [FEAT_W-1:0] feat_q [NUM_FEATURES];
   logic [NODE_W-1:0] nodeTable_q [NODES];

   logic              accept;
   logic              cfgWrite;
   logic [NODE_W-1:0] nodeWord;
   logic              isInternal;
   logic [SEL_W-1:0]  selField;
   logic [PREC_W-1:0] precField;
   logic [THR_W-1:0]  thrField;
   logic [AW-1:0]     leftIdx;
   logic [AW-1:0]     rightIdx;
   logic [FEAT_W-1:0] featSel;
   logic              goLeft;

   // Child pointers and write addresses are 6 bits wide regardless of table
   // depth, so anything past the end of the table wraps back into it.
   function automatic logic [AW-1:0] wrapIdx(input logic [CHILD_W-1:0] raw);
      return AW'(int'(raw) % NODES);
   endfunction

   assign accept   = (state_q == ST_IDLE) && in_valid_i;
   assign cfgWrite = (state_q == ST_IDLE) && cfg_we_i;

   assign nodeWord   = nodeTable_q[cur_q];
   assign isInternal = nodeWord[INT_BIT];
   assign selField   = nodeWord[SEL_LSB +: SEL_W];
   assign precField  = nodeWord[PREC_LSB +: PREC_W];
   assign thrField   = nodeWord[THR_LSB +: THR_W];
   assign leftIdx    = wrapIdx(nodeWord[LEFT_LSB +: CHILD_W]);
   assign rightIdx   = wrapIdx(nodeWord[RIGHT_LSB +: CHILD_W]);

   // Feature mux for the current node. Selects above 4 are trapped by the
   // FSM as an error, so the value chosen for them here never matters.
   always_comb begin
      featSel = feat_q[0];
      case (selField)
         3'd1:    featSel = feat_q[1];
         3'd2:    featSel = feat_q[2];
         3'd3:    featSel = feat_q[3];
         3'd4:    featSel = feat_q[4];
         default: featSel = feat_q[0];
      endcase
   end

   dtree_node_cmp uCmp (
      .feature_i   (featSel),
      .threshold_i (thrField),
      .precision_i (precField),
      .go_left_o   (goLeft)
   );

   // Walker FSM. The step limit is checked before the node itself, so a walk
   // that has already used its full budget aborts even if it lands on a leaf.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      steps_d = steps_q;
      class_d = class_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               state_d = ST_WALK;
               cur_d   = '0;
               steps_d = '0;
            end
         end
         ST_WALK: begin
            if (steps_q == SW'(MAX_STEPS)) begin
               state_d = ST_DONE;
               class_d = '0;
               err_d   = 1'b1;
            end else if (!isInternal) begin
               state_d = ST_DONE;
               class_d = thrField;
               err_d   = 1'b0;
            end else if (selField > SEL_W'(NUM_FEATURES - 1)) begin
               state_d = ST_DONE;
               class_d = '0;
               err_d   = 1'b1;
            end else begin
               cur_d   = goLeft ? leftIdx : rightIdx;
               steps_d = steps_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         steps_q <= '0;
         class_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         steps_q <= steps_d;
         class_q <= class_d;
         err_q   <= err_d;
      end
   end

   // Features are captured only on accept, so whatever the inputs do while a
   // walk is in flight cannot disturb it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_FEATURES; i++) begin
            feat_q[i] <= '0;
         end
      end else if (accept) begin
         feat_q[0] <= x0_i;
         feat_q[1] <= x1_i;
         feat_q[2] <= x2_i;
         feat_q[3] <= x3_i;
         feat_q[4] <= x4_i;
      end
   end

   // Node table. Writes are only taken in IDLE so the tree cannot change
   // under a walk; a write in the accept cycle lands before the first read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NODES; i++) begin
            nodeTable_q[i] <= '0;
         end
      end else if (cfgWrite) begin
         nodeTable_q[wrapIdx(cfg_addr_i)] <= cfg_data_i;
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign out_valid_o = (state_q == ST_DONE);
   assign out_class_o = class_q;
   assign out_err_o   = err_q;

endmodule

// File: tb/tb_dtree_walker.sv
// -----------------------------------------------------------------------------
// tb_dtree_walker
// Self-checking bench for dtree_walker: directed scenarios plus random trees
// compared against a behavioural tree-walk model kept in the bench.
// -----------------------------------------------------------------------------
module tb_dtree_walker;

   localparam int NODES     = 64;
   localparam int MAX_STEPS = 64;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [7:0]  xIn [5];
   logic        cfgWe;
   logic [5:0]  cfgAddr;
   logic [26:0] cfgData;
   logic        outValid;
   logic        outReady;
   logic [7:0]  outClass;
   logic        outErr;

   int compared   = 0;
   int mismatched = 0;

   logic [26:0] model [NODES];
   logic [7:0]  stimX [5];

   dtree_walker #(.NODES(NODES), .MAX_STEPS(MAX_STEPS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady),
      .x0_i        (xIn[0]),
      .x1_i        (xIn[1]),
      .x2_i        (xIn[2]),
      .x3_i        (xIn[3]),
      .x4_i        (xIn[4]),
      .cfg_we_i    (cfgWe),
      .cfg_addr_i  (cfgAddr),
      .cfg_data_i  (cfgData),
      .out_valid_o (outValid),
      .out_ready_i (outReady),
      .out_class_o (outClass),
      .out_err_o   (outErr)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected summary");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [26:0] mkInternal(int sel, int p, int thr, int l, int r);
      return 27'(1) | (27'(sel & 7) << 1) | (27'(p & 7) << 4) | (27'(thr & 255) << 7)
           | (27'(l & 63) << 15) | (27'(r & 63) << 21);
   endfunction

   function automatic logic [26:0] mkLeaf(int cls);
      return 27'(cls & 255) << 7;
   endfunction

   // Reference walk over the bench's own copy of the table: plain field
   // arithmetic, one loop iteration per internal node visited.
   task automatic refWalk(output int cls, output bit err, output int lat);
      int idx, steps, w, sel, sh, thr, fv;
      idx = 0; steps = 0; cls = 0; err = 1'b0;
      for (int k = 0; k <= MAX_STEPS + 1; k++) begin
         w = int'(model[idx]);
         if (steps == MAX_STEPS) begin err = 1'b1; cls = 0; break; end
         if ((w & 1) == 0) begin cls = (w >> 7) & 255; break; end
         sel = (w >> 1) & 7;
         if (sel > 4) begin err = 1'b1; cls = 0; break; end
         sh  = 7 - ((w >> 4) & 7);
         thr = (w >> 7) & 255;
         fv  = int'(stimX[sel]);
         if ((fv >> sh) <= (thr >> sh)) idx = ((w >> 15) & 63) % NODES;
         else                           idx = ((w >> 21) & 63) % NODES;
         steps++;
      end
      lat = 2 + steps;
   endtask

   task automatic randomizeInputs();
      for (int i = 0; i < 5; i++) xIn[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; inValid = 1'b0; cfgWe = 1'b0; outReady = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NODES; i++) model[i] = '0;
   endtask

   task automatic writeNode(input int a, input logic [26:0] d);
      @(negedge clk);
      cfgWe = 1'b1; cfgAddr = 6'(a); cfgData = d;
      model[a % NODES] = d;
      @(posedge clk);
      #1 cfgWe = 1'b0;
   endtask

   // Offers stimX, optionally with a same-cycle table write, then measures
   // cycles from the accept cycle to the first out_valid and takes the result.
   task automatic runSample(input bit doCfg, input int cA, input logic [26:0] cD,
                            output int cls, output bit err, output int lat,
                            output bit readyAtStart, output bit timedOut);
      @(negedge clk);
      readyAtStart = inReady;
      timedOut     = 1'b0;
      for (int i = 0; i < 5; i++) xIn[i] = stimX[i];
      inValid = 1'b1;
      if (doCfg) begin
         cfgWe = 1'b1; cfgAddr = 6'(cA); cfgData = cD;
         model[cA % NODES] = cD;
      end
      @(posedge clk);
      #1 inValid = 1'b0; cfgWe = 1'b0;
      randomizeInputs();
      lat = 1;
      @(negedge clk);
      while (!outValid && lat < 300) begin
         randomizeInputs();
         @(negedge clk);
         lat++;
      end
      if (!outValid) timedOut = 1'b1;
      cls = int'(outClass);
      err = outErr;
      outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; inValid = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgData = '0; outReady = 1'b0;
      for (int i = 0; i < 5; i++) xIn[i] = '0;
      for (int i = 0; i < NODES; i++) model[i] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
      compared++;
      if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
      compared++;
      if (outClass !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out_class: got %h expected 00", outClass); end
      compared++;
      if (outErr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_err: got %b expected 0", outErr); end
   endtask

   task automatic test_default_leaf();
      int cls, lat; bit err, rdy, to;
      doReset();
      for (int i = 0; i < 5; i++) stimX[i] = 8'($urandom_range(0, 255));
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || lat != 2) begin mismatched++; $display("[TB] FAIL default_latency: got %0d expected 2", lat); end
      compared++;
      if (cls != 0 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL default_result: got class %0d err %b expected 0/0", cls, err); end
   endtask

   task automatic test_split();
      int cls, lat; bit err, rdy, to;
      doReset();
      writeNode(0, mkInternal(2, 3, 8'h70, 1, 2));
      writeNode(1, mkLeaf(5));
      writeNode(2, mkLeaf(9));
      for (int i = 0; i < 5; i++) stimX[i] = 8'($urandom_range(0, 255));
      stimX[2] = 8'h7F;
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || cls != 5 || err !== 1'b0 || lat != 3) begin
         mismatched++; $display("[TB] FAIL split_left: got class %0d err %b lat %0d expected 5/0/3", cls, err, lat);
      end
      stimX[2] = 8'h80;
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || cls != 9 || err !== 1'b0 || lat != 3) begin
         mismatched++; $display("[TB] FAIL split_right: got class %0d err %b lat %0d expected 9/0/3", cls, err, lat);
      end
      compared++;
      if (rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL back_to_back_ready: got %b expected 1", rdy); end
   endtask

   task automatic test_abort();
      int cls, lat; bit err, rdy, to;
      doReset();
      writeNode(0, mkInternal(0, 0, 0, 0, 0));
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || cls != 0 || err !== 1'b1 || lat != 2 + MAX_STEPS) begin
         mismatched++; $display("[TB] FAIL abort_loop: got class %0d err %b lat %0d expected 0/1/%0d", cls, err, lat, 2 + MAX_STEPS);
      end
      writeNode(0, mkInternal(5, 7, 255, 1, 1));
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || cls != 0 || err !== 1'b1 || lat != 2) begin
         mismatched++; $display("[TB] FAIL abort_badsel: got class %0d err %b lat %0d expected 0/1/2", cls, err, lat);
      end
      runSample(1'b1, 0, mkLeaf(8'h33), cls, err, lat, rdy, to);
      compared++;
      if (to || cls != 8'h33 || err !== 1'b0 || lat != 2) begin
         mismatched++; $display("[TB] FAIL cfg_same_cycle: got class %0d err %b lat %0d expected 51/0/2", cls, err, lat);
      end
   endtask

   task automatic test_backpressure();
      int cls, lat, wait_n; bit err, rdy, to, bad;
      doReset();
      writeNode(0, mkInternal(2, 3, 8'h70, 1, 2));
      writeNode(1, mkLeaf(5));
      writeNode(2, mkLeaf(9));
      stimX[2] = 8'h10;
      @(negedge clk);
      for (int i = 0; i < 5; i++) xIn[i] = stimX[i];
      inValid = 1'b1;
      @(posedge clk);
      #1 inValid = 1'b0;
      wait_n = 0;
      @(negedge clk);
      while (!outValid && wait_n < 300) begin @(negedge clk); wait_n++; end
      compared++;
      if (!outValid) begin mismatched++; $display("[TB] FAIL bp_wait: got timeout expected out_valid"); end
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (outValid !== 1'b1 || outClass !== 8'd5 || outErr !== 1'b0 || inReady !== 1'b0) begin
            bad = 1'b1;
            $display("[TB] FAIL bp_hold_cycle%0d: got v%b c%0d e%b r%b expected v1 c5 e0 r0", c, outValid, outClass, outErr, inReady);
         end
         cfgWe = 1'b1; cfgAddr = 6'd1; cfgData = mkLeaf(8'hAA);
         inValid = 1'b1;
         randomizeInputs();
         @(negedge clk);
      end
      compared++;
      if (bad) mismatched++;
      cfgWe = 1'b0; inValid = 1'b0; outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || rdy !== 1'b1 || cls != 5 || err !== 1'b0 || lat != 3) begin
         mismatched++; $display("[TB] FAIL bp_write_ignored: got class %0d err %b lat %0d rdy %b expected 5/0/3/1", cls, err, lat, rdy);
      end
   endtask

   task automatic test_reset_midwalk();
      int cls, lat; bit err, rdy, to, sawValid;
      doReset();
      writeNode(0, mkInternal(0, 7, 255, 1, 1));
      writeNode(1, mkInternal(1, 7, 255, 2, 2));
      writeNode(2, mkInternal(2, 7, 255, 3, 3));
      writeNode(3, mkLeaf(7));
      @(negedge clk);
      for (int i = 0; i < 5; i++) xIn[i] = 8'($urandom_range(0, 255));
      inValid = 1'b1;
      @(posedge clk);
      #1 inValid = 1'b0;
      @(negedge clk);
      sawValid = outValid;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NODES; i++) model[i] = '0;
      compared++;
      if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", inReady); end
      for (int c = 0; c < 8; c++) begin
         if (outValid) sawValid = 1'b1;
         @(negedge clk);
      end
      compared++;
      if (sawValid) begin mismatched++; $display("[TB] FAIL rst_mid_no_valid: got out_valid 1 expected 0"); end
      for (int i = 0; i < 5; i++) stimX[i] = 8'($urandom_range(0, 255));
      runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
      compared++;
      if (to || cls != 0 || err !== 1'b0 || lat != 2) begin
         mismatched++; $display("[TB] FAIL rst_mid_cleared: got class %0d err %b lat %0d expected 0/0/2", cls, err, lat);
      end
   endtask

   task automatic test_random();
      int lvl [NODES];
      bit used [NODES];
      int nextFree, cls, lat, eCls, eLat, sel;
      bit err, eErr, rdy, to;
      logic [26:0] w;
      for (int t = 0; t < 8; t++) begin
         doReset();
         for (int i = 0; i < NODES; i++) begin used[i] = 1'b0; lvl[i] = 0; end
         used[0] = 1'b1;
         nextFree = 1;
         for (int i = 0; i < NODES; i++) begin
            if (!used[i] || lvl[i] >= 10 || nextFree > NODES - 2 || $urandom_range(0, 9) < 3) begin
               w = mkLeaf(int'($urandom_range(0, 255)));
            end else begin
               sel = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
               w = mkInternal(sel, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), nextFree, nextFree + 1);
               used[nextFree] = 1'b1; used[nextFree + 1] = 1'b1;
               lvl[nextFree] = lvl[i] + 1; lvl[nextFree + 1] = lvl[i] + 1;
               nextFree += 2;
            end
            writeNode(i, w);
         end
         for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < 5; i++) stimX[i] = 8'($urandom_range(0, 255));
            refWalk(eCls, eErr, eLat);
            runSample(1'b0, 0, '0, cls, err, lat, rdy, to);
            compared++;
            if (to || rdy !== 1'b1 || cls != eCls || err !== eErr || lat != eLat) begin
               mismatched++;
               $display("[TB] FAIL random_t%0d_s%0d: got class %0d err %b lat %0d rdy %b expected %0d/%b/%0d/1",
                        t, s, cls, err, lat, rdy, eCls, eErr, eLat);
            end
         end
      end
   endtask

   // Scenarios run back to back; each one resets the design itself.
   initial begin
      test_reset();
      test_default_leaf();
      test_split();
      test_abort();
      test_backpressure();
      test_reset_midwalk();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dtree_walker.md
DTREE_WALKER -- requirements
Module: dtree_walker

Interface
REQ-001 Parameter NODES, default 64, node-table depth; node address width is log2(NODES).
REQ-002 Parameter MAX_STEPS, default 64, maximum internal nodes visited per sample before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  sample offered.
REQ-006 in_ready  output  1  walker can accept a sample.
REQ-007 X0..X4  input  8 each  feature values, sampled on the in_valid&&in_ready cycle.
REQ-008 cfg_we  input  1  node-table write strobe.
REQ-009 cfg_addr  input  6  node index to write.
REQ-010 cfg_data  input  27  node word.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_class  output  8  class of the reached leaf.
REQ-014 out_err  output  1  walk aborted.

Function
REQ-015 Node word layout: [0] internal flag (0 = leaf); [3:1] feature select 0..4; [6:4] precision p (compares the upper p+1 bits); [14:7] threshold, or class when leaf; [20:15] left child; [26:21] right child.
REQ-016 Internal node: go left when X_sel[7:7-p] <= thr[7:7-p] (unsigned); otherwise go right.
REQ-017 States: IDLE, WALK, DONE; in_ready = (state==IDLE).
REQ-018 IDLE: on in_valid&&in_ready, latch X0..X4, set cur=0, steps=0, go to WALK.
REQ-019 WALK: evaluate one node per cycle, read combinationally from the table at cur.
  - Internal node: cur <= chosen child, steps += 1.
  - Leaf: latch out_class = node[14:7], out_err = 0, go to DONE.
REQ-020 In WALK, if steps == MAX_STEPS, or an internal node has feature select > 4: go to DONE with out_class = 0 and out_err = 1.
REQ-021 DONE: out_valid = 1; out_class and out_err stay stable until out_valid&&out_ready, then return to IDLE.
REQ-022 Latency: a sample accepted at cycle T with d internal nodes on its path gives out_valid first high at T+2+d.
REQ-023 Throughput: one sample in flight at a time; the earliest next accept is the cycle after the result handshake.
REQ-024 cfg_we is honoured only in IDLE; it is ignored in WALK and DONE, so the tree stays consistent for the whole walk.
REQ-025 If cfg_we and a sample accept occur in the same IDLE cycle: the write commits, and the walk starting next cycle sees the new word.
REQ-026 Out-of-range children (>= NODES) wrap modulo NODES.
REQ-027 Latched features are never modified during WALK or DONE, whatever happens on X0..X4.

Reset
REQ-028 On rst: state = IDLE, out_valid = 0, out_class = 0, out_err = 0, cur = 0, steps = 0.
REQ-029 On rst: all node words are cleared to 0, i.e. every node becomes a leaf of class 0.
REQ-030 rst asserted mid-walk or in DONE aborts the sample with no out_valid pulse; in_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-031 Shared package dtree_pkg holds: NODE_W = 27, the node field offsets and widths, NUM_FEATURES = 5, FEAT_W = 8, and the state enum.
REQ-032 One sub-module, dtree_node_cmp: inputs feature, threshold and precision; output go_left (combinational).
REQ-033 Node table: a register array inside dtree_walker, no memory macro.

Verification
REQ-034 After reset, no writes, send a sample -> out_valid at T+2, out_class = 0, out_err = 0.
REQ-035 Node0 = {X2, p=3, thr=0x70, L=1, R=2}, node1 = leaf 5, node2 = leaf 9.
  - X2 = 0x7F -> class 5 at T+3.
  - X2 = 0x80 -> class 9 at T+3.
REQ-036 Node0 = internal with both children 0 -> out_err = 1, out_class = 0, out_valid at T+2+MAX_STEPS.
REQ-037 Hold out_ready = 0 for 10 cycles in DONE, with a cfg_we write and in_valid = 1 during that time -> outputs stable, write ignored, in_ready = 0; the result completes on the out_ready pulse.
REQ-038 Assert rst in the cycle after an accept on a depth-3 path -> no out_valid; table cleared; in_ready = 1 after rst deasserts.
REQ-039 Random trees (depth <= 10) and random samples against a software reference model -> class and latency match exactly.
